// File: rtl/misc_sequencer.sv
// Round-robin sequencer that time-shares one external Misc datapath between NREQ requesters.
// Define MISC_SEQ_STATS_EN to add the OP_COUNT handshake counter and the BUSY flag.
module misc_sequencer #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ_VALID,
    output logic [NREQ-1:0]     REQ_READY,
    input  logic [NREQ*8-1:0]   REQ_A,
    input  logic [NREQ*4-1:0]   REQ_B,
    input  logic [NREQ*8-1:0]   REQ_C,
    output logic [7:0]          DP_A,
    output logic [3:0]          DP_B,
    output logic [7:0]          DP_C,
    input  logic [7:0]          DP_X1,
    input  logic [7:0]          DP_X2,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [IDW-1:0]      RES_ID,
    output logic [7:0]          RES_X1,
    output logic [7:0]          RES_X2,
`ifdef MISC_SEQ_STATS_EN
    output logic [15:0]         OP_COUNT,
    output logic                BUSY,
`endif
    output logic [1:0]          dbg_state
);
    // Handshakes: a request transfers on a cycle where REQ_VALID[i] and REQ_READY[i] are both
    // high; a result transfers on a cycle where RES_VALID and RES_READY are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [3:0]      op_b_q, op_b_d;
    logic [7:0]      op_c_q, op_c_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [7:0]      res_x1_q, res_x1_d;
    logic [7:0]      res_x2_q, res_x2_d;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand_idx;

    // Scan from rr_ptr upward, wrapping modulo NREQ; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && REQ_VALID[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_c_d    = op_c_q;
        op_id_d   = op_id_q;
        res_id_d  = res_id_q;
        res_x1_d  = res_x1_q;
        res_x2_d  = res_x2_q;
        REQ_READY = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (IDW'(i) == grant_idx) begin
                            REQ_READY[i] = 1'b1;
                            op_a_d       = REQ_A[8*i +: 8];
                            op_b_d       = REQ_B[4*i +: 4];
                            op_c_d       = REQ_C[8*i +: 8];
                        end
                    end
                    op_id_d  = grant_idx;
                    rr_ptr_d = IDW'((int'(grant_idx) + 1) % NREQ);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_x1_d = DP_X1;
                res_x2_d = DP_X2;
                res_id_d = op_id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (RES_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
            op_id_q  <= '0;
            res_id_q <= '0;
            res_x1_q <= '0;
            res_x2_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_c_q   <= op_c_d;
            op_id_q  <= op_id_d;
            res_id_q <= res_id_d;
            res_x1_q <= res_x1_d;
            res_x2_q <= res_x2_d;
        end
    end

    // Operand registers only change on accept, so DP_* hold their last value outside EXEC.
    assign DP_A      = op_a_q;
    assign DP_B      = op_b_q;
    assign DP_C      = op_c_q;
    assign RES_VALID = (state_q == RESP);
    assign RES_ID    = res_id_q;
    assign RES_X1    = res_x1_q;
    assign RES_X2    = res_x2_q;
    assign dbg_state = state_q;

`ifdef MISC_SEQ_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (RES_VALID && RES_READY) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign OP_COUNT = op_count_q;
    assign BUSY     = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_misc_sequencer.sv
// Directed bench for misc_sequencer: expected responses are queued by the stimulus and
// consumed by an independent monitor that watches the result channel.
module tb_misc_sequencer;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int W    = 24;

    logic              CLK;
    logic              RST;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_READY;
    logic [NREQ*8-1:0] REQ_A;
    logic [NREQ*4-1:0] REQ_B;
    logic [NREQ*8-1:0] REQ_C;
    logic [7:0]        DP_A;
    logic [3:0]        DP_B;
    logic [7:0]        DP_C;
    logic [7:0]        DP_X1;
    logic [7:0]        DP_X2;
    logic              RES_VALID;
    logic              RES_READY;
    logic [IDW-1:0]    RES_ID;
    logic [7:0]        RES_X1;
    logic [7:0]        RES_X2;
    logic [1:0]        dbg_state;
`ifdef MISC_SEQ_STATS_EN
    logic [15:0]       OP_COUNT;
    logic              BUSY;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    misc_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C),
        .DP_A(DP_A), .DP_B(DP_B), .DP_C(DP_C),
        .DP_X1(DP_X1), .DP_X2(DP_X2),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_ID(RES_ID), .RES_X1(RES_X1), .RES_X2(RES_X2),
`ifdef MISC_SEQ_STATS_EN
        .OP_COUNT(OP_COUNT), .BUSY(BUSY),
`endif
        .dbg_state(dbg_state)
    );

    // Misc datapath stand-in: XOUT1 = A ^ C, XOUT2 = A - B + C + 5 (mod 256).
    assign DP_X1 = DP_A ^ DP_C;
    assign DP_X2 = DP_A - {4'b0, DP_B} + DP_C + 8'd5;

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int id, input logic [7:0] x1, input logic [7:0] x2);
        exp_q.push_back({8'(id), x1, x2});
    endfunction

    task automatic wait_grant(input int id, input string name);
        int cyc;
        cyc = 0;
        @(negedge CLK);
        while (REQ_READY == '0 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk(name, 32'(REQ_READY), 32'(1) << id);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            @(negedge CLK);
            cyc++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0]      act;
        logic [W-1:0]      exp;
        logic              hold_vld;
        logic [IDW+15:0]   hold_val;
        hold_vld = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    n_vec++;
                    if (!RES_VALID || {RES_ID, RES_X1, RES_X2} !== hold_val) begin
                        n_err++;
                        $display("FAIL hold_stable: got v=%0b %0h, expected v=1 %0h",
                                 RES_VALID, {RES_ID, RES_X1, RES_X2}, hold_val);
                    end
                end
                act = {8'(RES_ID), RES_X1, RES_X2};
                if (RES_VALID && RES_READY) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_resp: got 0x%0h, expected no response", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            n_err++;
                            $display("FAIL resp: got id/x1/x2 0x%06h, expected 0x%06h", act, exp);
                        end
                    end
                    hold_vld = 1'b0;
                end else if (RES_VALID) begin
                    hold_vld = 1'b1;
                    hold_val = {RES_ID, RES_X1, RES_X2};
                end else begin
                    hold_vld = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int cyc;
        int grants;
        int last;
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_A     = '0;
        REQ_B     = '0;
        REQ_C     = '0;
        RES_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_req_ready", 32'(REQ_READY), 32'd0);
        chk("rst_dp", 32'({DP_A, DP_B, DP_C}), 32'd0);
        chk("rst_res", 32'({RES_ID, RES_X1, RES_X2}), 32'd0);
`ifdef MISC_SEQ_STATS_EN
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_op_count", 32'(OP_COUNT), 32'd0);
`endif

        // Single request from requester 0: A=10 B=3 C=4 -> X1=14, X2=16
        @(posedge CLK);
        #1;
        REQ_A = {8'd0, 8'd10};
        REQ_B = {4'd0, 4'd3};
        REQ_C = {8'd0, 8'd4};
        REQ_VALID = 2'b01;
        push_exp(0, 8'd14, 8'd16);
        wait_grant(0, "single_grant");
        @(posedge CLK);
        #1 REQ_VALID = '0;
        @(negedge CLK);
        chk("exec_ready_low", 32'(REQ_READY), 32'd0);
        chk("exec_res_valid", 32'(RES_VALID), 32'd0);
        chk("exec_dp", 32'({DP_A, DP_B, DP_C}), 32'({8'd10, 4'd3, 8'd4}));
`ifdef MISC_SEQ_STATS_EN
        chk("exec_busy", 32'(BUSY), 32'd1);
`endif
        @(negedge CLK);
        chk("latency_res_valid", 32'(RES_VALID), 32'd1);
        wait_drain("single_drain");

        // Both requesters valid; rr_ptr is 1 after granting 0, so grants go 1,0,1,0 every 3 cycles
        @(posedge CLK);
        #1;
        REQ_A = {8'h55, 8'h20};
        REQ_B = {4'hA, 4'h1};
        REQ_C = {8'hAA, 8'h0F};
        push_exp(1, 8'hFF, 8'hFA);
        push_exp(0, 8'h2F, 8'h33);
        push_exp(1, 8'hFF, 8'hFA);
        push_exp(0, 8'h2F, 8'h33);
        REQ_VALID = 2'b11;
        cyc = 0;
        grants = 0;
        last = 0;
        while (grants < 4 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (REQ_READY != '0) begin
                chk("alt_grant", 32'(REQ_READY), (grants % 2 == 0) ? 32'd2 : 32'd1);
                if (grants > 0) chk("alt_interval", 32'(cyc - last), 32'd3);
                last = cyc;
                grants++;
            end
        end
        chk("alt_grant_count", 32'(grants), 32'd4);
        @(posedge CLK);
        #1 REQ_VALID = '0;
        wait_drain("alt_drain");

        // Backpressure on the wrap vector: A=2 B=15 C=0xFF -> X1=0xFD, X2=247
        @(posedge CLK);
        #1;
        RES_READY = 1'b0;
        REQ_A = {8'h02, 8'h80};
        REQ_B = {4'hF, 4'h8};
        REQ_C = {8'hFF, 8'h01};
        REQ_VALID = 2'b10;
        push_exp(1, 8'hFD, 8'hF7);
        wait_grant(1, "bp_grant");
        @(posedge CLK);
        #1 REQ_VALID = '0;
        cyc = 0;
        @(negedge CLK);
        while (!RES_VALID && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        chk("bp_res_valid", 32'(RES_VALID), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            if (i == 0) begin
                REQ_VALID = 2'b01;
                push_exp(0, 8'h81, 8'h7E);
            end
            @(negedge CLK);
            chk("bp_valid_held", 32'(RES_VALID), 32'd1);
            chk("bp_ready_low", 32'(REQ_READY), 32'd0);
        end
        @(posedge CLK);
        #1 RES_READY = 1'b1;
        @(negedge CLK);
        chk("bp_release_ready_low", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        chk("bp_done_valid", 32'(RES_VALID), 32'd0);
        chk("bp_next_grant", 32'(REQ_READY), 32'd1);
        @(posedge CLK);
        #1 REQ_VALID = '0;
        wait_drain("bp_drain");
`ifdef MISC_SEQ_STATS_EN
        chk("op_count_7", 32'(OP_COUNT), 32'd7);
`endif

        // Reset during EXEC discards the request; rr_ptr (1 here) returns to 0
        @(posedge CLK);
        #1;
        REQ_A = {8'h00, 8'h11};
        REQ_B = {4'h0, 4'h1};
        REQ_C = {8'h00, 8'h22};
        REQ_VALID = 2'b01;
        wait_grant(0, "rst_mid_grant");
        @(posedge CLK);
        #1;
        REQ_VALID = '0;
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_state", 32'(dbg_state), 32'd0);
        chk("rst_mid_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_mid_dp_a", 32'(DP_A), 32'd0);
        chk("rst_mid_res", 32'({RES_ID, RES_X1, RES_X2}), 32'd0);
`ifdef MISC_SEQ_STATS_EN
        chk("rst_mid_op_count", 32'(OP_COUNT), 32'd0);
`endif
        @(posedge CLK);
        #1;
        REQ_A = {8'h44, 8'h33};
        REQ_B = {4'h4, 4'h3};
        REQ_C = {8'h44, 8'h10};
        REQ_VALID = 2'b11;
        push_exp(0, 8'h23, 8'h45);
        @(negedge CLK);
        chk("rst_rr_ptr_zero", 32'(REQ_READY), 32'd1);
        @(posedge CLK);
        #1 REQ_VALID = '0;
        wait_drain("fresh_drain");
        repeat (4) @(negedge CLK);
`ifdef MISC_SEQ_STATS_EN
        chk("op_count_1", 32'(OP_COUNT), 32'd1);
`endif
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
